regfile_sb: RTL and testbench
=============================

# regfile_sb

Parametrised integer register file with hardware clear sweep, per-register scoreboard and optional write-to-read bypass. It is the next-generation register file for the pipelined core, sitting between decode (two read ports, scoreboard lookup) and writeback (one write port). It also provides a debug read port for the test harness. It replaces fixed 32×32 storage and per-register debug outputs with a width/depth-parametrised array and a single addressed debug port.

## Interface
- `XLEN`, 32, data width in bits
- `NREGS`, 32, number of architectural registers (power of two, ≥4); `AW = $clog2(NREGS)`
- `clk` input 1: the block's only clock; all state updates on its rising edge
- `rst_n` input 1: asynchronous, active-low reset
- `ra1`, `ra2` input AW: read addresses
- `rd1`, `rd2` output XLEN: read data (combinational)
- `busy1`, `busy2` output 1: scoreboard pending bit for `ra1` / `ra2`
- `we` input 1: write enable
- `wa` input AW: write address
- `wd` input XLEN: write data
- `alloc_v` input 1: mark destination pending (issue of a producer)
- `alloc_a` input AW: destination to mark
- `clr_req` input 1: request a full register clear
- `ready` output 1: array is valid and accepts writes and allocations
- `dbg_a` input AW: debug read address
- `dbg_d` output XLEN: debug read data (combinational, never bypassed)

## Operation
- **FSM states.** CLEAR and IDLE.
  - Reset forces state CLEAR, sweep index `idx`=1, `ready`=0 and all pending bits 0. The array itself has no reset.
- **CLEAR.**
  - Each rising edge writes 0 to entry `idx` and increments `idx`.
  - After writing `NREGS-1`, the FSM moves to IDLE.
  - `we`, `alloc_v` and `clr_req` are ignored.
  - `rd1`, `rd2` and `dbg_d` read 0.
  - `busy1` and `busy2` read 0.
- **IDLE.**
  - `clr_req`=1 → next state CLEAR, `idx`=1, all pending bits cleared.
  - A write or allocation in the same cycle as `clr_req` is dropped.
- **Register 0.**
  - Reads always return 0; writes to it are discarded.
  - Its pending bit is never set.
- **Write.** `we`=1 in IDLE → `Reg[wa]<=wd` and `pend[wa]<=0` at the rising edge.
- **Allocate.** `alloc_v`=1 in IDLE with `alloc_a`≠0 → `pend[alloc_a]<=1`.
  - If `alloc_a`==`wa` with `we`=1 in the same cycle, the allocation wins: data is written and the pending bit is set.
- **Read.**
  - `rdN = Reg[raN]`, subject to bypass (see Configuration).
  - `busyN = pend[raN]`, not bypassed: a write in the current cycle does not clear `busyN` until the next cycle.

## Timing
- **Reset values:** `ready`=0; `rd1`, `rd2`, `dbg_d` = 0; `busy1`, `busy2` = 0.
- **Clear duration.** `ready` rises at the `NREGS-1`-th rising edge after `rst_n` deasserts, or after the cycle in which `clr_req` was accepted.
  - For default parameters this is 31 cycles.
- **Write latency.** Stored data is visible from the cycle after the write edge.
  - Bypassed data, when enabled, is visible in the same cycle.
- **Mid-operation reset.** `rst_n` asserted during CLEAR or IDLE immediately restarts the sweep at `idx`=1.
  - A partially cleared array must not be observable: reads return 0 until `ready`=1.
- **Width rules.** Addresses are exactly AW bits, so no out-of-range case exists. `idx` is AW bits and never wraps past `NREGS-1`.

## Configuration
- **`REGFILE_BYPASS_EN` defined:** write-to-read bypass is compiled in.
  - If `we`=1, `wa`≠0, state IDLE and `raN`==`wa`, then `rdN`=`wd` combinationally in the same cycle.
- **`REGFILE_BYPASS_EN` undefined:** `rdN` returns only stored contents; decode must stall one cycle on the hazard.
- `dbg_d` is never bypassed in either configuration.

## Test plan
- Release `rst_n` and poll `ready` → `ready`=0 for 30 edges and 1 from edge 31. All reads return 0, including `ra1`=5 immediately after reset.
- In IDLE, write `wa`=3, `wd`=0xDEADBEEF, with `ra1`=3 in the same cycle.
  - With `REGFILE_BYPASS_EN`: `rd1`=0xDEADBEEF in that cycle.
  - Without it: `rd1`=0 in that cycle and 0xDEADBEEF in the next.
- Write `wa`=0, `wd`=0x1234 together with `alloc_a`=0 → `rd1` (with `ra1`=0) = 0 and `busy1`=0 forever.
- Allocate `alloc_a`=7, then write `wa`=7 two cycles later → `busy2` (with `ra2`=7) is 1 for 2 cycles, then 0. Simultaneous write and allocate to 9 → `busy` for 9 = 1 and data stored.
- Fill registers 1–31, then pulse `clr_req` → `ready` drops next cycle, returns after 31 cycles, all registers read 0 and all pending bits are 0. A `we` pulse during CLEAR has no effect.
- Assert `rst_n`=0 mid-CLEAR at `idx`=10 → sweep restarts at 1, and `ready` rises 31 edges after release.

Source files
------------

// File: rtl/regfile_sb_if.sv
// Register-file port bundle: decode read/scoreboard lookup, writeback write, allocation, clear and debug.
// Latency: n/a (wiring only).
// Backpressure: none; the ready signal tells the pipeline when writes and allocations take effect.
interface regfile_sb_if #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
);
    localparam int AW = $clog2(NREGS);

    logic [AW-1:0]   ra1;
    logic [AW-1:0]   ra2;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic            busy1;
    logic            busy2;
    logic            we;
    logic [AW-1:0]   wa;
    logic [XLEN-1:0] wd;
    logic            alloc_v;
    logic [AW-1:0]   alloc_a;
    logic            clr_req;
    logic            ready;
    logic [AW-1:0]   dbg_a;
    logic [XLEN-1:0] dbg_d;

    modport master (
        output ra1, ra2, we, wa, wd, alloc_v, alloc_a, clr_req, dbg_a,
        input  rd1, rd2, busy1, busy2, ready, dbg_d
    );

    modport slave (
        input  ra1, ra2, we, wa, wd, alloc_v, alloc_a, clr_req, dbg_a,
        output rd1, rd2, busy1, busy2, ready, dbg_d
    );
endinterface

// File: rtl/regfile_sb.sv
// Parametrised register file with clear sweep, per-register scoreboard; REGFILE_BYPASS_EN adds write-to-read bypass.
// Latency: reads combinational; writes visible next cycle (same cycle when bypassed); clear sweep takes NREGS-1 cycles.
// Backpressure: while sweeping, ready=0 and writes, allocations and clear requests are ignored; reads return 0.
module regfile_sb #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    regfile_sb_if.slave rf
);
    localparam int            AW   = $clog2(NREGS);
    localparam logic [AW-1:0] LAST = AW'(NREGS - 1);
    localparam logic [AW-1:0] ONE  = AW'(1);

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [AW-1:0]   idx;
    logic [AW-1:0]   idx_nxt;
    logic [NREGS-1:0] pend;
    logic [NREGS-1:0] pend_nxt;
    logic            wr_en;
    logic            ready;
    logic [XLEN-1:0] mem [NREGS];
    logic [XLEN-1:0] stored1;
    logic [XLEN-1:0] stored2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= CLEAR;
            idx   <= ONE;
            pend  <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            pend  <= pend_nxt;
        end
    end

    // An allocation to the register being written lands after the write's clear, so it wins.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        pend_nxt  = pend;
        wr_en     = 1'b0;
        if (state == CLEAR) begin
            if (idx == LAST) begin
                state_nxt = IDLE;
            end else begin
                idx_nxt = idx + ONE;
            end
        end else if (rf.clr_req) begin
            state_nxt = CLEAR;
            idx_nxt   = ONE;
            pend_nxt  = '0;
        end else begin
            wr_en = rf.we && (rf.wa != '0);
            if (rf.we) begin
                pend_nxt[rf.wa] = 1'b0;
            end
            if (rf.alloc_v && (rf.alloc_a != '0)) begin
                pend_nxt[rf.alloc_a] = 1'b1;
            end
        end
    end

    // Entry 0 is never written; its reads are forced to zero below.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[idx] <= '0;
        end else if (wr_en) begin
            mem[rf.wa] <= rf.wd;
        end
    end

    assign ready    = (state == IDLE);
    assign rf.ready = ready;

    // Gating on ready hides a partially swept array.
    assign stored1  = (ready && (rf.ra1 != '0)) ? mem[rf.ra1] : '0;
    assign stored2  = (ready && (rf.ra2 != '0)) ? mem[rf.ra2] : '0;
    assign rf.dbg_d = (ready && (rf.dbg_a != '0)) ? mem[rf.dbg_a] : '0;

    assign rf.busy1 = ready && pend[rf.ra1];
    assign rf.busy2 = ready && pend[rf.ra2];

`ifdef REGFILE_BYPASS_EN
    logic byp_ok;
    assign byp_ok = ready && rf.we && (rf.wa != '0);
    assign rf.rd1 = (byp_ok && (rf.ra1 == rf.wa)) ? rf.wd : stored1;
    assign rf.rd2 = (byp_ok && (rf.ra2 == rf.wa)) ? rf.wd : stored2;
`else
    assign rf.rd1 = stored1;
    assign rf.rd2 = stored2;
`endif
endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: directed vector table, reset/clear sequences and random traffic against a behavioural model.
module tb_regfile_sb;
    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int AW    = 5;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    regfile_sb_if #(.XLEN(XLEN), .NREGS(NREGS)) rf();
    regfile_sb #(.XLEN(XLEN), .NREGS(NREGS)) dut (.clk(clk), .rst_n(rst_n), .rf(rf));

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model: cycles of clearing left, architectural contents, pending flags.
    logic [XLEN-1:0] m_reg [NREGS];
    logic            m_pend [NREGS];
    int              m_left;

    typedef struct {
        logic            we;
        logic [AW-1:0]   wa;
        logic [XLEN-1:0] wd;
        logic            av;
        logic [AW-1:0]   aa;
        logic [AW-1:0]   ra1;
        logic [AW-1:0]   ra2;
        logic [XLEN-1:0] e_rd1;
        logic [XLEN-1:0] e_rd2;
        logic            e_b1;
        logic            e_b2;
    } vec_t;
    vec_t tbl [10];

    task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void m_reset();
        m_left = NREGS - 1;
        for (int i = 0; i < NREGS; i++) begin
            m_reg[i]  = '0;
            m_pend[i] = 1'b0;
        end
    endfunction

    function automatic logic [XLEN-1:0] m_rd(input logic [AW-1:0] a);
        if (m_left != 0 || a == 0) return '0;
        if (BYP && rf.we && rf.wa != 0 && a == rf.wa) return rf.wd;
        return m_reg[a];
    endfunction

    task automatic check_model();
        chk("ready", rf.ready, (m_left == 0));
        chk("rd1", rf.rd1, m_rd(rf.ra1));
        chk("rd2", rf.rd2, m_rd(rf.ra2));
        chk("busy1", rf.busy1, (m_left == 0) && m_pend[rf.ra1]);
        chk("busy2", rf.busy2, (m_left == 0) && m_pend[rf.ra2]);
        chk("dbg_d", rf.dbg_d, (m_left == 0) ? m_reg[rf.dbg_a] : '0);
    endtask

    function automatic void model_edge();
        if (!rst_n) begin
            m_reset();
        end else if (m_left > 0) begin
            m_left--;
        end else if (rf.clr_req) begin
            m_reset();
        end else begin
            if (rf.we && rf.wa != 0) m_reg[rf.wa] = rf.wd;
            if (rf.we) m_pend[rf.wa] = 1'b0;
            if (rf.alloc_v && rf.alloc_a != 0) m_pend[rf.alloc_a] = 1'b1;
        end
    endfunction

    task automatic set_in(input logic we, input logic [AW-1:0] wa, input logic [XLEN-1:0] wd,
                          input logic av, input logic [AW-1:0] aa, input logic clr,
                          input logic [AW-1:0] ra1, input logic [AW-1:0] ra2, input logic [AW-1:0] dbg);
        rf.we = we; rf.wa = wa; rf.wd = wd; rf.alloc_v = av; rf.alloc_a = aa;
        rf.clr_req = clr; rf.ra1 = ra1; rf.ra2 = ra2; rf.dbg_a = dbg;
    endtask

    task automatic finish_cycle();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic cyc(input logic we, input logic [AW-1:0] wa, input logic [XLEN-1:0] wd,
                       input logic av, input logic [AW-1:0] aa, input logic clr,
                       input logic [AW-1:0] ra1, input logic [AW-1:0] ra2, input logic [AW-1:0] dbg);
        set_in(we, wa, wd, av, aa, clr, ra1, ra2, dbg);
        @(negedge clk);
        check_model();
        finish_cycle();
    endtask

    task automatic idle(input logic [AW-1:0] ra1, input logic [AW-1:0] ra2, input logic [AW-1:0] dbg);
        cyc(1'b0, '0, '0, 1'b0, '0, 1'b0, ra1, ra2, dbg);
    endtask

    // Counts edges until ready, throwing ignored traffic at the block while it sweeps.
    task automatic wait_ready(input string name);
        int n = 0;
        while (rf.ready !== 1'b1 && n < 100) begin
            cyc(1'($urandom), AW'($urandom), $urandom, 1'($urandom), AW'($urandom), 1'($urandom),
                AW'($urandom), AW'($urandom), AW'($urandom));
            n++;
        end
        chk(name, n, 31);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{1, 3, 32'hDEADBEEF, 0, 0, 3, 0, BYP ? 32'hDEADBEEF : 32'h0, 0, 0, 0};
        tbl[1] = '{0, 0, 0,            0, 0, 3, 0, 32'hDEADBEEF, 0, 0, 0};
        tbl[2] = '{1, 0, 32'h1234,     1, 0, 0, 0, 0, 0, 0, 0};
        tbl[3] = '{0, 0, 0,            0, 0, 0, 3, 0, 32'hDEADBEEF, 0, 0};
        tbl[4] = '{0, 0, 0,            1, 7, 0, 7, 0, 0, 0, 0};
        tbl[5] = '{0, 0, 0,            0, 0, 0, 7, 0, 0, 0, 1};
        tbl[6] = '{1, 7, 32'h77,       0, 0, 0, 7, 0, BYP ? 32'h77 : 32'h0, 0, 1};
        tbl[7] = '{0, 0, 0,            0, 0, 0, 7, 0, 32'h77, 0, 0};
        tbl[8] = '{1, 9, 32'h99,       1, 9, 9, 9, BYP ? 32'h99 : 32'h0, BYP ? 32'h99 : 32'h0, 0, 0};
        tbl[9] = '{0, 0, 0,            0, 0, 9, 9, 32'h99, 32'h99, 1, 1};

        // Power-on reset and first sweep
        set_in(0, 0, 0, 0, 0, 0, 5, 5, 5);
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        m_reset();
        #1;
        chk("reset ready", rf.ready, 0);
        chk("reset rd1", rf.rd1, 0);
        chk("reset busy1", rf.busy1, 0);
        chk("reset dbg_d", rf.dbg_d, 0);
        idle(5, 5, 5);
        idle(5, 5, 5);
        rst_n = 1'b1;
        chk("rd1 after reset", rf.rd1, 0);
        wait_ready("reset sweep length");

        // Directed vectors
        for (int i = 0; i < 10; i++) begin
            set_in(tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].av, tbl[i].aa, 1'b0, tbl[i].ra1, tbl[i].ra2, '0);
            @(negedge clk);
            check_model();
            chk($sformatf("tbl%0d rd1", i), rf.rd1, tbl[i].e_rd1);
            chk($sformatf("tbl%0d rd2", i), rf.rd2, tbl[i].e_rd2);
            chk($sformatf("tbl%0d busy1", i), rf.busy1, tbl[i].e_b1);
            chk($sformatf("tbl%0d busy2", i), rf.busy2, tbl[i].e_b2);
            finish_cycle();
        end

        // Fill everything, allocate some, then clear
        for (int r = 1; r < NREGS; r++)
            cyc(1'b1, AW'(r), $urandom, (r % 3 == 0), AW'(r), 1'b0, AW'(r), '0, AW'(r - 1));
        cyc(1'b0, '0, '0, 1'b0, '0, 1'b1, 4, 6, 8);
        chk("ready drop after clr", rf.ready, 0);
        wait_ready("clear sweep length");
        for (int r = 0; r < NREGS; r++) begin
            idle(AW'(r), AW'(r), AW'(r));
            chk("cleared rd1", rf.rd1, 0);
            chk("cleared busy2", rf.busy2, 0);
            chk("cleared dbg_d", rf.dbg_d, 0);
        end

        // Reset in the middle of a sweep (idx has reached 10)
        for (int r = 1; r < NREGS; r++)
            cyc(1'b1, AW'(r), $urandom, 1'b0, '0, 1'b0, '0, '0, '0);
        cyc(1'b0, '0, '0, 1'b0, '0, 1'b1, 0, 0, 0);
        repeat (9) idle(12, 20, 30);
        rst_n = 1'b0;
        m_reset();
        #1;
        chk("mid reset ready", rf.ready, 0);
        chk("mid reset rd2", rf.rd2, 0);
        idle(12, 20, 30);
        rst_n = 1'b1;
        wait_ready("restarted sweep length");

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            logic [AW-1:0] wa;
            wa = AW'($urandom);
            cyc(1'($urandom), wa, $urandom, ($urandom_range(2, 0) == 0), AW'($urandom),
                ($urandom_range(99, 0) == 0),
                ($urandom_range(3, 0) == 0) ? wa : AW'($urandom),
                ($urandom_range(3, 0) == 0) ? wa : AW'($urandom),
                AW'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
